// File: rtl/updown_sweep_ctrl_pkg.sv
// rtl/updown_sweep_ctrl_pkg.sv - shared state encoding and default widths for the triangle sweep controller
package updown_sweep_ctrl_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_DWELL_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP      = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_LO = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/updown_load_counter.sv
// rtl/updown_load_counter.sv - loadable N-bit up/down counter, falling-edge, async active-low reset
module updown_load_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] count
);

    localparam logic [N-1:0] ONE = 1;

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up ? (count_q + ONE) : (count_q - ONE);
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - bounded lo->hi->lo sweep sequencer with per-bound dwell and continuous mode
module updown_sweep_ctrl
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [N-1:0]       lo,
    input  logic [N-1:0]       hi,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N-1:0]       count,
    output logic               dir_up,
    output logic               busy,
    output logic               at_bound,
    output logic               done
);

    localparam logic [DWELL_W-1:0] DW_ONE = 1;

    sweep_state_t       state_q, state_d;
    logic [N-1:0]       lo_q, lo_d;
    logic [N-1:0]       hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic               done_q, done_d;

    logic               cnt_load;
    logic               cnt_en;
    logic               cnt_up;
    logic               exit_lo;

    updown_load_counter #(.N(N)) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (lo),
        .en       (cnt_en),
        .up       (cnt_up),
        .count    (count)
    );

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        dwell_d  = dwell_q;
        dcnt_d   = dcnt_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_up   = 1'b1;
        exit_lo  = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        lo_d     = lo;
                        hi_d     = hi;
                        dwell_d  = dwell;
                        cnt_load = 1'b1;
                        // An empty or inverted range completes immediately without going busy.
                        if (lo < hi) begin
                            state_d = ST_UP;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_UP: begin
                    if (count != hi_q) begin
                        cnt_en = 1'b1;
                    end else if (dwell_q == '0) begin
                        state_d = ST_DOWN;
                        cnt_en  = 1'b1;
                        cnt_up  = 1'b0;
                    end else begin
                        state_d = ST_HOLD_HI;
                        dcnt_d  = dwell_q - DW_ONE;
                    end
                end
                ST_HOLD_HI: begin
                    if (dcnt_q == '0) begin
                        state_d = ST_DOWN;
                        cnt_en  = 1'b1;
                        cnt_up  = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q - DW_ONE;
                    end
                end
                ST_DOWN: begin
                    if (count != lo_q) begin
                        cnt_en = 1'b1;
                        cnt_up = 1'b0;
                    end else if (dwell_q == '0) begin
                        exit_lo = 1'b1;
                    end else begin
                        state_d = ST_HOLD_LO;
                        dcnt_d  = dwell_q - DW_ONE;
                    end
                end
                ST_HOLD_LO: begin
                    if (dcnt_q == '0) begin
                        exit_lo = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q - DW_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // continuous is read live here so software can end a repeating sweep cleanly at lo.
            if (exit_lo) begin
                if (continuous) begin
                    state_d = ST_UP;
                    cnt_en  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dwell_q <= dwell_d;
            dcnt_q  <= dcnt_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign dir_up   = !((state_q == ST_DOWN) || (state_q == ST_HOLD_LO));
    assign at_bound = busy && ((count == lo_q) || (count == hi_q));
    assign done     = done_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - scoreboard bench for updown_sweep_ctrl
module tb_updown_sweep_ctrl;

    localparam int N  = 4;
    localparam int DW = 4;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic          continuous;
    logic [N-1:0]  lo;
    logic [N-1:0]  hi;
    logic [DW-1:0] dwell;
    logic [N-1:0]  count;
    logic          dir_up;
    logic          busy;
    logic          at_bound;
    logic          done;

    typedef struct packed {
        logic [N-1:0] count;
        logic         dir_up;
        logic         busy;
        logic         at_bound;
        logic         done;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    updown_sweep_ctrl #(.N(N), .DWELL_W(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .lo         (lo),
        .hi         (hi),
        .dwell      (dwell),
        .count      (count),
        .dir_up     (dir_up),
        .busy       (busy),
        .at_bound   (at_bound),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input obs_t e);
        obs_t o;
        o = {count, dir_up, busy, at_bound, done};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed count=%0d dir_up=%b busy=%b at_bound=%b done=%b expected count=%0d dir_up=%b busy=%b at_bound=%b done=%b",
                   tag, o.count, o.dir_up, o.busy, o.at_bound, o.done,
                   e.count, e.dir_up, e.busy, e.at_bound, e.done);
        end
    endtask

    task automatic push(input int c, input bit d, input bit b, input bit a, input bit dn);
        exp_q.push_back({N'(c), d, b, a, dn});
    endtask

    // Expected triangle: one entry per cycle, bounds held for 1+dwell cycles.
    task automatic push_sweep(input int l, input int h, input int dw, input bit first, input bit last);
        for (int c = (first ? l : l + 1); c < h; c++) push(c, 1'b1, 1'b1, (c == l), 1'b0);
        for (int k = 0; k <= dw; k++) push(h, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int c = h - 1; c > l; c--) push(c, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= dw; k++) push(l, 1'b0, 1'b1, 1'b1, 1'b0);
        if (last) begin
            push(l, 1'b1, 1'b0, 1'b0, 1'b1);
            push(l, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic step();
        obs_t e;
        @(posedge clk);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            check("seq", e);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            step();
            guard++;
        end
    endtask

    task automatic launch(input int l, input int h, input int dw);
        @(posedge clk);
        lo    = N'(l);
        hi    = N'(h);
        dwell = DW'(dw);
        start = 1'b1;
    endtask

    initial begin
        int n1;
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        lo         = '0;
        hi         = '0;
        dwell      = '0;

        @(posedge clk);
        check("reset", {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        reset_n = 1'b1;
        @(posedge clk);
        check("post_reset", {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        // basic sweep, no dwell
        launch(2, 5, 0);
        push_sweep(2, 5, 0, 1'b1, 1'b1);
        step();
        start = 1'b0;
        drain();

        // dwell 2 at each bound
        launch(1, 3, 2);
        push_sweep(1, 3, 2, 1'b1, 1'b1);
        step();
        start = 1'b0;
        drain();

        // full-range continuous, dropped mid-DOWN of the second pass
        continuous = 1'b1;
        launch(0, 15, 0);
        push_sweep(0, 15, 0, 1'b1, 1'b0);
        n1 = exp_q.size();
        push_sweep(0, 15, 0, 1'b0, 1'b1);
        step();
        start = 1'b0;
        for (int i = 1; i < n1 + 20; i++) step();
        continuous = 1'b0;
        drain();

        // stop at count 4 while ascending, then stop+start together in IDLE
        launch(1, 8, 0);
        push(1, 1'b1, 1'b1, 1'b1, 1'b0);
        push(2, 1'b1, 1'b1, 1'b0, 1'b0);
        push(3, 1'b1, 1'b1, 1'b0, 1'b0);
        push(4, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        step();
        step();
        step();
        stop = 1'b1;
        push(4, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        start = 1'b1;
        lo    = 4'd2;
        hi    = 4'd9;
        push(4, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        start = 1'b0;
        stop  = 1'b0;
        push(4, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // degenerate ranges complete at once without going busy
        launch(7, 7, 0);
        push(7, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        start = 1'b0;
        push(7, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        launch(9, 3, 0);
        push(9, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        start = 1'b0;
        push(9, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // async reset while holding at hi
        launch(1, 3, 5);
        push(1, 1'b1, 1'b1, 1'b1, 1'b0);
        push(2, 1'b1, 1'b1, 1'b0, 1'b0);
        push(3, 1'b1, 1'b1, 1'b1, 1'b0);
        push(3, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        start = 1'b0;
        drain();
        #2 reset_n = 1'b0;
        #1 check("async_reset", {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        check("after_async_reset", {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
